// File: rtl/isl_mode_seq_pkg.sv
// Shared types for the ISL51002 mode sequencer: state encoding, field widths
// and the mode record that is qualified, latched and compared frame to frame.
package isl_mode_seq_pkg;

    localparam int VTOTAL_W = 11;
    localparam int PCNT_W   = 20;

    typedef enum logic [1:0] {
        ST_NO_SYNC = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [VTOTAL_W-1:0] vtotal;
        logic                interlace;
        logic [PCNT_W-1:0]   pcnt;
    } mode_rec_t;

    // Unsigned operands are widened by one bit so the difference never wraps.
    function automatic logic pcnt_within(input logic [PCNT_W-1:0] a,
                                         input logic [PCNT_W-1:0] b,
                                         input logic [PCNT_W:0]   tol);
        logic signed [PCNT_W:0] diff;
        logic        [PCNT_W:0] mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[PCNT_W] ? $unsigned(-diff) : $unsigned(diff);
        return (mag <= tol);
    endfunction

endpackage

// File: rtl/isl_mode_sequencer_watchdog.sv
// Frame-tick watchdog: counts clk27 cycles between ticks while running and
// pulses expired on the terminal count unless a tick arrives that same cycle.
module sync_watchdog #(
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = run && !kick && (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run || kick || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/isl_mode_sequencer.sv
// Video mode qualifier/locker between the ISL51002 measurements and the CPU.
// Build option MODE_SEQ_HYST_EN: tolerate one isolated mismatching frame while locked.
module isl_mode_sequencer
    import isl_mode_seq_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int PCNT_TOL       = 8,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                clk27,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic                frame_tick_i,
    input  logic [VTOTAL_W-1:0] vtotal_i,
    input  logic                interlace_i,
    input  logic [PCNT_W-1:0]   pcnt_frame_i,
    input  logic                irq_ack_i,
    output logic                mode_valid_o,
    output logic [VTOTAL_W-1:0] mode_vtotal_o,
    output logic                mode_interlace_o,
    output logic [PCNT_W-1:0]   mode_pcnt_o,
    output logic                irq_o,
    output logic                resync_req_o,
    output logic [1:0]          state_o,
    output logic [7:0]          change_cnt_o
);
    localparam logic [3:0]      SF_W  = STABLE_FRAMES[3:0];
    localparam logic [PCNT_W:0] TOL_W = PCNT_TOL[PCNT_W:0];

    seq_state_e state_q;
    mode_rec_t  cand_q;
    mode_rec_t  mode_q;
    mode_rec_t  in_mode;
    mode_rec_t  lock_src;
    logic [3:0] stable_cnt_q;
    logic [3:0] stable_cnt_d;
    logic       mode_valid_q;
    logic       irq_q;
    logic       resync_req_q;
    logic [7:0] change_cnt_q;
    logic       cand_match;
    logic       wd_run;
    logic       wd_expired;
    logic       tick;
    logic       do_lock;
`ifdef MODE_SEQ_HYST_EN
    logic       miss_q;
`endif

    assign in_mode      = '{vtotal: vtotal_i, interlace: interlace_i, pcnt: pcnt_frame_i};
    assign tick         = enable_i && frame_tick_i;
    assign stable_cnt_d = stable_cnt_q + 4'd1;
    assign cand_match   = (vtotal_i == cand_q.vtotal) && (interlace_i == cand_q.interlace)
                          && pcnt_within(pcnt_frame_i, cand_q.pcnt, TOL_W);
    assign wd_run       = enable_i && (state_q != ST_NO_SYNC);

    // Locking from NO_SYNC (single-frame qualification) takes the live frame.
    assign lock_src = (state_q == ST_NO_SYNC) ? in_mode : cand_q;
    assign do_lock  = tick && !wd_expired &&
                      (((state_q == ST_NO_SYNC) && (STABLE_FRAMES == 1)) ||
                       ((state_q == ST_ACQUIRE) && cand_match && (stable_cnt_d >= SF_W)));

    sync_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk27   (clk27),
        .reset_n (reset_n),
        .run     (wd_run),
        .kick    (tick),
        .expired (wd_expired)
    );

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            state_q      <= ST_NO_SYNC;
            cand_q       <= '0;
            mode_q       <= '0;
            stable_cnt_q <= '0;
            mode_valid_q <= 1'b0;
            irq_q        <= 1'b0;
            resync_req_q <= 1'b0;
            change_cnt_q <= '0;
`ifdef MODE_SEQ_HYST_EN
            miss_q       <= 1'b0;
`endif
        end else begin
            resync_req_q <= 1'b0;
            if (irq_ack_i) begin
                irq_q <= 1'b0;
            end
            if (!enable_i || wd_expired) begin
                if (state_q == ST_LOCKED) begin
                    irq_q        <= 1'b1;
                    change_cnt_q <= change_cnt_q + 8'd1;
                end
                state_q      <= ST_NO_SYNC;
                mode_valid_q <= 1'b0;
                stable_cnt_q <= '0;
`ifdef MODE_SEQ_HYST_EN
                miss_q       <= 1'b0;
`endif
            end else if (frame_tick_i) begin
                if ((state_q == ST_ACQUIRE) && cand_match) begin
                    stable_cnt_q <= stable_cnt_d;
                end else if ((state_q == ST_LOCKED) && cand_match) begin
`ifdef MODE_SEQ_HYST_EN
                    miss_q <= 1'b0;
`endif
                end
`ifdef MODE_SEQ_HYST_EN
                else if ((state_q == ST_LOCKED) && !miss_q) begin
                    miss_q <= 1'b1;
                end
`endif
                else begin
                    if (state_q == ST_LOCKED) begin
                        mode_valid_q <= 1'b0;
                        irq_q        <= 1'b1;
                        change_cnt_q <= change_cnt_q + 8'd1;
                    end
                    cand_q       <= in_mode;
                    stable_cnt_q <= 4'd1;
                    state_q      <= ST_ACQUIRE;
`ifdef MODE_SEQ_HYST_EN
                    miss_q       <= 1'b0;
`endif
                end
                if (do_lock) begin
                    state_q      <= ST_LOCKED;
                    mode_q       <= lock_src;
                    mode_valid_q <= 1'b1;
                    irq_q        <= 1'b1;
                    resync_req_q <= 1'b1;
                    change_cnt_q <= change_cnt_q + 8'd1;
                end
            end
        end
    end

    assign mode_valid_o     = mode_valid_q;
    assign mode_vtotal_o    = mode_q.vtotal;
    assign mode_interlace_o = mode_q.interlace;
    assign mode_pcnt_o      = mode_q.pcnt;
    assign irq_o            = irq_q;
    assign resync_req_o     = resync_req_q;
    assign state_o          = state_q;
    assign change_cnt_o     = change_cnt_q;

endmodule

// File: tb/tb_isl_mode_sequencer.sv
// Bench for isl_mode_sequencer: directed scenarios then random traffic, all
// checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_isl_mode_sequencer;
    localparam int SF  = 4;
    localparam int TOL = 8;
    localparam int TO  = 40;
`ifdef MODE_SEQ_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        frame_tick_i = 1'b0;
    logic [10:0] vtotal_i = '0;
    logic        interlace_i = 1'b0;
    logic [19:0] pcnt_frame_i = '0;
    logic        irq_ack_i = 1'b0;
    logic        mode_valid_o;
    logic [10:0] mode_vtotal_o;
    logic        mode_interlace_o;
    logic [19:0] mode_pcnt_o;
    logic        irq_o;
    logic        resync_req_o;
    logic [1:0]  state_o;
    logic [7:0]  change_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = no sync, 1 = acquiring, 2 = locked.
    int          m_state, m_cnt, m_frames, m_idle;
    bit          m_valid, m_irq, m_resync, m_miss;
    logic [10:0] m_mv, c_v;
    bit          m_mi, c_i;
    logic [19:0] m_mp, c_p;

    always #5 clk27 = ~clk27;

    isl_mode_sequencer #(.STABLE_FRAMES(SF), .PCNT_TOL(TOL), .TIMEOUT_CYCLES(TO)) dut (
        .clk27(clk27), .reset_n(reset_n), .enable_i(enable_i), .frame_tick_i(frame_tick_i),
        .vtotal_i(vtotal_i), .interlace_i(interlace_i), .pcnt_frame_i(pcnt_frame_i),
        .irq_ack_i(irq_ack_i), .mode_valid_o(mode_valid_o), .mode_vtotal_o(mode_vtotal_o),
        .mode_interlace_o(mode_interlace_o), .mode_pcnt_o(mode_pcnt_o), .irq_o(irq_o),
        .resync_req_o(resync_req_o), .state_o(state_o), .change_cnt_o(change_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic enter_lock();
        m_state = 2; m_valid = 1; m_irq = 1; m_resync = 1;
        m_cnt = (m_cnt + 1) % 256;
        m_mv = c_v; m_mi = c_i; m_mp = c_p;
    endtask

    task automatic model_step(input bit rstn, input bit en, input bit tk, input logic [10:0] v,
                              input bit il, input logic [19:0] p, input bit ack);
        bit t, hit, lose, from_nosync;
        m_resync = 0;
        if (!rstn) begin
            m_state = 0; m_valid = 0; m_irq = 0; m_cnt = 0; m_frames = 0; m_idle = 0; m_miss = 0;
            m_mv = '0; m_mi = 0; m_mp = '0; c_v = '0; c_i = 0; c_p = '0;
            return;
        end
        if (ack) m_irq = 0;
        t    = tk && en;
        hit  = (v == c_v) && (il == c_i) &&
               (int'(p) - int'(c_p) <= TOL) && (int'(c_p) - int'(p) <= TOL);
        lose = !en || (m_state != 0 && !t && m_idle == TO - 1);
        if (lose) begin
            if (m_state == 2) begin
                m_irq = 1;
                m_cnt = (m_cnt + 1) % 256;
            end
            m_state = 0; m_valid = 0; m_frames = 0; m_idle = 0; m_miss = 0;
        end else if (t) begin
            m_idle = 0;
            if (m_state == 2 && hit) begin
                m_miss = 0;
            end else if (m_state == 2 && HYST && !m_miss) begin
                m_miss = 1;
            end else if (m_state == 1 && hit) begin
                m_frames++;
                if (m_frames >= SF) enter_lock();
            end else begin
                from_nosync = (m_state == 0);
                if (m_state == 2) begin
                    m_valid = 0; m_irq = 1;
                    m_cnt = (m_cnt + 1) % 256;
                end
                c_v = v; c_i = il; c_p = p; m_frames = 1; m_miss = 0;
                m_state = 1;
                if (from_nosync && SF == 1) enter_lock();
            end
        end else if (m_state != 0) begin
            m_idle++;
        end
    endtask

    task automatic cycle(input bit rstn, input bit en, input bit tk, input logic [10:0] v,
                         input bit il, input logic [19:0] p, input bit ack);
        @(negedge clk27);
        reset_n = rstn; enable_i = en; frame_tick_i = tk;
        vtotal_i = v; interlace_i = il; pcnt_frame_i = p; irq_ack_i = ack;
        model_step(rstn, en, tk, v, il, p, ack);
        @(posedge clk27);
        #1;
        check_eq("state", state_o, m_state);
        check_eq("valid", mode_valid_o, m_valid);
        check_eq("irq", irq_o, m_irq);
        check_eq("resync", resync_req_o, m_resync);
        check_eq("chg_cnt", change_cnt_o, m_cnt);
        check_eq("mode_vt", mode_vtotal_o, m_mv);
        check_eq("mode_il", mode_interlace_o, m_mi);
        check_eq("mode_pc", mode_pcnt_o, m_mp);
    endtask

    task automatic tick(input logic [10:0] v, input logic [19:0] p);
        cycle(1, 1, 1, v, 0, p, 0);
    endtask

    task automatic idle(input int n, input bit ack);
        for (int k = 0; k < n; k++) cycle(1, 1, 0, '0, 0, '0, ack);
    endtask

    task automatic lock_at(input logic [10:0] v, input logic [19:0] p);
        for (int k = 0; k < SF; k++) begin
            idle(1, 0);
            tick(v, p);
        end
    endtask

    initial begin
        int gap, sp, p;
        bit rs, en, ack, tk, si;
        logic [10:0] sv;

        cycle(0, 0, 0, '0, 0, '0, 0);
        cycle(0, 1, 0, '0, 0, '0, 0);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_valid", mode_valid_o, 0);
        check_eq("rst_irq", irq_o, 0);
        check_eq("rst_chg", change_cnt_o, 0);

        // First lock: visible right after the 4th tick.
        lock_at(262, 223440);
        check_eq("lock_valid", mode_valid_o, 1);
        check_eq("lock_resync", resync_req_o, 1);
        check_eq("lock_irq", irq_o, 1);
        check_eq("lock_chg", change_cnt_o, 1);
        check_eq("lock_pcnt", mode_pcnt_o, 223440);
        idle(1, 1);
        check_eq("resync_1cyc", resync_req_o, 0);
        check_eq("ack_clear", irq_o, 0);

        // Tolerance edge: +7 stays, +9 breaks.
        tick(262, 223447);
        check_eq("tol_in_state", state_o, 2);
        tick(262, 223449);
`ifdef MODE_SEQ_HYST_EN
        check_eq("hyst_hold", state_o, 2);
        tick(262, 223449);
`endif
        check_eq("tol_out_state", state_o, 1);
        check_eq("tol_out_valid", mode_valid_o, 0);
        check_eq("tol_out_irq", irq_o, 1);
        check_eq("tol_out_chg", change_cnt_o, 2);
        for (int k = 0; k < SF - 1; k++) begin
            idle(1, 0);
            tick(262, 223449);
        end
        check_eq("relock_state", state_o, 2);
        check_eq("relock_pcnt", mode_pcnt_o, 223449);

        // Tick on the terminal-count cycle keeps lock; silence then drops it.
        idle(1, 1);
        idle(TO - 2, 0);
        tick(262, 223449);
        check_eq("tc_tick_state", state_o, 2);
        idle(TO - 1, 0);
        check_eq("pre_to_state", state_o, 2);
        idle(1, 1);
        check_eq("to_state", state_o, 0);
        check_eq("to_irq_ack_same", irq_o, 1);
        check_eq("to_chg", change_cnt_o, 4);
        idle(1, 1);
        check_eq("ack_alone", irq_o, 0);

        // Candidate restart in ACQUIRE.
        for (int k = 0; k < 3; k++) begin idle(1, 0); tick(262, 223440); end
        idle(1, 0); tick(263, 223440);
        check_eq("restart_state", state_o, 1);
        for (int k = 0; k < 2; k++) begin idle(1, 0); tick(263, 223440); end
        check_eq("restart_not_yet", state_o, 1);
        idle(1, 0); tick(263, 223440);
        check_eq("restart_lock", state_o, 2);
        check_eq("restart_vt", mode_vtotal_o, 263);

        cycle(1, 0, 1, 263, 0, 223440, 0);
        check_eq("dis_state", state_o, 0);
        check_eq("dis_chg", change_cnt_o, 6);

`ifdef MODE_SEQ_HYST_EN
        lock_at(262, 223440);
        tick(300, 223440);
        tick(262, 223440);
        check_eq("hyst_single", state_o, 2);
        tick(300, 223440);
        tick(301, 223440);
        check_eq("hyst_double", state_o, 1);
`endif
        lock_at(262, 223440);
        cycle(0, 1, 0, '0, 0, '0, 0);
        check_eq("midrst_state", state_o, 0);
        check_eq("midrst_irq", irq_o, 0);
        check_eq("midrst_pcnt", mode_pcnt_o, 0);

        // Random traffic with occasional mode changes, gaps near the timeout,
        // disables, acks and resets.
        gap = 0; sv = 262; si = 0; sp = 223440;
        for (int n = 0; n < 5000; n++) begin
            rs  = ($urandom_range(0, 599) != 0);
            en  = ($urandom_range(0, 79) != 0);
            ack = ($urandom_range(0, 7) == 0);
            tk  = 0;
            p   = sp;
            if (gap == 0) begin
                tk = 1;
                if ($urandom_range(0, 19) == 0) gap = $urandom_range(TO - 2, TO + 1);
                else gap = $urandom_range(1, 5);
                if ($urandom_range(0, 29) == 0) begin
                    sv = ($urandom_range(0, 1) != 0) ? 11'd262 : 11'd263;
                    si = ($urandom_range(0, 3) == 0);
                    sp = 223440 + $urandom_range(0, 40);
                end
                if ($urandom_range(0, 9) == 0) p = sp + $urandom_range(0, 24) - 12;
                else p = sp + $urandom_range(0, 8) - 4;
            end else begin
                gap--;
            end
            cycle(rs, en, tk, sv, si, p[19:0], ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isl_mode_sequencer.md
Name: isl_mode_sequencer

Overview:
- Control block in the clk27 domain between the ISL51002 frontend measurement outputs and the NIOS/scanconverter.
- Qualifies the incoming video mode over consecutive frames, watches for sync loss and latches a stable mode record.
- Raises a CPU interrupt on every lock, change or loss event.
- Issues a one-cycle resync request so the scanconverter restarts only on a stable mode.

Parameters:
- STABLE_FRAMES, 4: consecutive matching frames required to lock; legal range 1..15.
- PCNT_TOL, 8: allowed absolute difference in pcnt_frame between frames for a match.
- TIMEOUT_CYCLES, 2700000: clk27 cycles without frame_tick before sync-loss is declared (100 ms).

Ports:
- clk27  in  1  system clock, 27 MHz.
- reset_n  in  1  synchronous, active-low reset.
- enable_i  in  1  block enable from sys_ctrl; 0 forces the NO_SYNC state.
- frame_tick_i  in  1  single-cycle pulse per input frame, already synchronized to clk27.
- vtotal_i  in  11  measured lines per frame; valid when frame_tick_i=1.
- interlace_i  in  1  interlace flag; valid when frame_tick_i=1.
- pcnt_frame_i  in  20  measured pixel clocks per frame; valid when frame_tick_i=1.
- irq_ack_i  in  1  CPU write pulse that clears irq_o.
- mode_valid_o  out  1  1 only in the LOCKED state.
- mode_vtotal_o  out  11  latched vtotal of the locked mode.
- mode_interlace_o  out  1  latched interlace flag of the locked mode.
- mode_pcnt_o  out  20  latched pcnt_frame of the locked mode.
- irq_o  out  1  level interrupt, sticky until acknowledged.
- resync_req_o  out  1  one-cycle pulse on entry to LOCKED.
- state_o  out  2  current state: 0 NO_SYNC, 1 ACQUIRE, 2 LOCKED.
- change_cnt_o  out  8  count of lock/unlock events, wraps at 255 to 0.

Behaviour:
- Reset is synchronous and active-low. When reset_n=0 at a clk27 edge:
  - state becomes NO_SYNC;
  - every output becomes 0;
  - the candidate registers, stable counter and watchdog counter become 0.
- Reset mid-operation discards the candidate and the locked mode; no irq is raised.
- Match rule, evaluated only on frame_tick_i=1. All three must hold:
  - vtotal_i equals cand_vtotal;
  - interlace_i equals cand_interlace;
  - |pcnt_frame_i − cand_pcnt| ≤ PCNT_TOL, using a 21-bit signed difference with no wrap.
- Recapture: load the cand_* registers from the inputs and set stable_cnt to 1.
- NO_SYNC:
  - On a tick: recapture, then go to ACQUIRE.
  - If STABLE_FRAMES=1, go directly to LOCKED instead.
- ACQUIRE:
  - Tick and match: stable_cnt+1. When the new value equals STABLE_FRAMES, go to LOCKED.
  - Tick and mismatch: recapture and stay in ACQUIRE.
- LOCKED entry (registered, visible the cycle after the qualifying tick):
  - latch the cand_* values into the mode_* outputs;
  - mode_valid_o=1, irq_o=1, resync_req_o=1 for exactly one cycle;
  - change_cnt_o+1.
- LOCKED:
  - Tick and match: stay. The candidate registers do not track drift.
  - Tick and mismatch: mode_valid_o=0, irq_o=1, change_cnt_o+1, recapture, go to ACQUIRE.
  - mode_* outputs hold their last locked values until the next lock.
- Watchdog, active in ACQUIRE and LOCKED:
  - the counter clears on every tick and otherwise increments;
  - on reaching TIMEOUT_CYCLES−1, go to NO_SYNC, mode_valid_o=0, stable_cnt=0;
  - if leaving LOCKED this way: irq_o=1 and change_cnt_o+1.
  - The counter is held at 0 in NO_SYNC.
  - A tick in the same cycle as the terminal count wins: the tick is processed and the counter clears.
- enable_i=0: behaves like the timeout — same transition to NO_SYNC, including irq if leaving LOCKED. Ticks are ignored while disabled.
- irq_o: set on lock, change or loss. irq_ack_i clears it. If a set and an ack occur in the same cycle, set wins.
- Latency: the first lock appears STABLE_FRAMES ticks plus 1 cycle after leaving NO_SYNC.

Optional Feature:
- Macro: MODE_SEQ_HYST_EN.
- Defined: in LOCKED, a single mismatching tick only increments a 1-bit miss flag. A matching tick clears the flag. A second consecutive mismatch causes the LOCKED→ACQUIRE transition, recapturing from that second frame.
- Undefined: the first mismatch in LOCKED leaves LOCKED immediately; no miss flag exists.

Decomposition:
- Package isl_mode_seq_pkg:
  - state encoding constants ST_NO_SYNC=2'd0, ST_ACQUIRE=2'd1, ST_LOCKED=2'd2;
  - widths VTOTAL_W=11, PCNT_W=20.
- Sub-module sync_watchdog:
  - holds the timeout counter;
  - inputs: clk27, reset_n, run, kick; output: expired pulse; parameter TIMEOUT_CYCLES.

Test Plan:
- Reset → state_o=0, all outputs 0; 4 ticks with vtotal=262, interlace=0, pcnt=223440 → mode_valid_o=1 the cycle after the 4th tick; resync_req_o high for 1 cycle; irq_o=1; change_cnt_o=1.
- Locked at pcnt=223440; tick with pcnt=223447 → stays locked; tick with pcnt=223449 → mode_valid_o=0, irq_o=1, state_o=1 (MODE_SEQ_HYST_EN undefined).
- Lock, then no ticks for 2700000 cycles → state_o=0, irq_o=1, change_cnt_o=2; a tick on the terminal-count cycle → stays LOCKED.
- ACQUIRE with 3 matches, 4th tick vtotal=263 → stable_cnt restarts; lock occurs only after 3 more matching ticks at 263.
- irq_ack_i asserted in the same cycle as a loss event → irq_o remains 1; a later ack alone → irq_o=0.
- MODE_SEQ_HYST_EN defined: single mismatch then match → stays LOCKED; two consecutive mismatches → ACQUIRE. Mid-lock reset_n=0 for 1 cycle → all outputs 0, irq_o=0.
